// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI burst sequencer: FSM state encoding and the
// default byte transmitted when a burst outruns the TX FIFO.
package spi_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_WAIT_RDY = 2'd3
    } seq_state_e;

    localparam logic [7:0] SPI_SEQ_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous FIFO with a combinational head view, so the consumer sees the
// oldest entry as soon as it is written. Depth must be a power of two.
module spi_seq_fifo #(
    parameter int DATA_BW    = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic                        i_wr_en,
    input  logic [DATA_BW-1:0]          i_wr_data,
    input  logic                        i_rd_en,
    output logic [DATA_BW-1:0]          o_rd_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(FIFO_DEPTH):0] o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [DATA_BW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               wr_ok, rd_ok;

    assign o_full    = (count_q == FULL_CNT);
    assign o_empty   = (count_q == '0);
    assign o_count   = count_q;
    assign o_rd_data = mem_q[rd_ptr_q];
    assign wr_ok     = i_wr_en && !o_full;
    assign rd_ok     = i_rd_en && !o_empty;

    // Pointers are exactly AW bits wide, so they wrap modulo the depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

endmodule

// File: rtl/spi_burst_sequencer.sv
// Runs N-byte bursts through spi_controller as back-to-back single-byte transfers,
// buffering TX and RX bytes in FIFOs. Define SPI_SEQ_FILL_EN to send FILL_BYTE on TX underflow.
module spi_burst_sequencer
    import spi_seq_pkg::*;
#(
    parameter int                 DATA_BW    = 8,
    parameter int                 LEN_BW     = 8,
    parameter int                 FIFO_DEPTH = 16,
    parameter logic [DATA_BW-1:0] FILL_BYTE  = DATA_BW'(SPI_SEQ_FILL_BYTE)
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_wr_en,
    input  logic [DATA_BW-1:0] i_wr_data,
    output logic               o_tx_full,
    input  logic               i_start,
    input  logic [LEN_BW-1:0]  i_len,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_rx_valid,
    output logic [DATA_BW-1:0] o_rx_data,
    input  logic               i_rx_ready,
    output logic               o_rx_drop,
    output logic               o_spi_tx_en,
    output logic [DATA_BW-1:0] o_spi_tx_data,
    input  logic               i_spi_tx_ready,
    input  logic               i_spi_rx_ack,
    input  logic [DATA_BW-1:0] i_spi_rx_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    seq_state_e         state_q, state_d;
    logic [LEN_BW-1:0]  cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tx_en_q, tx_en_d;
    logic [DATA_BW-1:0] tx_data_q, tx_data_d;
    logic               drop_q, drop_d;
    logic               seen_low_q, seen_low_d;

    logic               tx_pop, rx_push;
    logic               tx_empty, rx_full, rx_empty;
    logic [DATA_BW-1:0] tx_head;
    logic [CW-1:0]      tx_count, rx_count;
    logic               unused_levels;

    spi_seq_fifo #(
        .DATA_BW    (DATA_BW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_wr_en   (i_wr_en),
        .i_wr_data (i_wr_data),
        .i_rd_en   (tx_pop),
        .o_rd_data (tx_head),
        .o_full    (o_tx_full),
        .o_empty   (tx_empty),
        .o_count   (tx_count)
    );

    spi_seq_fifo #(
        .DATA_BW    (DATA_BW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_wr_en   (rx_push),
        .i_wr_data (i_spi_rx_data),
        .i_rd_en   (i_rx_ready),
        .o_rd_data (o_rx_data),
        .o_full    (rx_full),
        .o_empty   (rx_empty),
        .o_count   (rx_count)
    );

    assign o_rx_valid    = !rx_empty;
    assign unused_levels = ^{tx_count, rx_count};

`ifndef SPI_SEQ_FILL_EN
    logic unused_fill;
    assign unused_fill = ^FILL_BYTE;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        tx_en_d    = 1'b0;
        tx_data_d  = tx_data_q;
        drop_d     = 1'b0;
        seen_low_d = seen_low_q;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_len != '0) begin
                        cnt_d   = i_len;
                        state_d = ST_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            ST_ISSUE: begin
                seen_low_d = 1'b0;
`ifdef SPI_SEQ_FILL_EN
                if (i_spi_tx_ready) begin
                    tx_en_d = 1'b1;
                    state_d = ST_WAIT_ACK;
                    if (!tx_empty) begin
                        tx_pop    = 1'b1;
                        tx_data_d = tx_head;
                    end else begin
                        tx_data_d = FILL_BYTE;
                    end
                end
`else
                if (i_spi_tx_ready && !tx_empty) begin
                    tx_en_d   = 1'b1;
                    tx_pop    = 1'b1;
                    tx_data_d = tx_head;
                    state_d   = ST_WAIT_ACK;
                end
`endif
            end

            ST_WAIT_ACK: begin
                if (!i_spi_tx_ready) begin
                    seen_low_d = 1'b1;
                end
                if (i_spi_rx_ack) begin
                    // A dropped byte still completes its slot in the burst.
                    if (rx_full) begin
                        drop_d = 1'b1;
                    end else begin
                        rx_push = 1'b1;
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_BW'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_RDY;
                    end
                end
            end

            ST_WAIT_RDY: begin
                // Only a ready that was seen low since the last issue counts as a rising edge.
                if (!i_spi_tx_ready) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    state_d = ST_ISSUE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= '0;
            drop_q     <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_en_q    <= tx_en_d;
            tx_data_q  <= tx_data_d;
            drop_q     <= drop_d;
            seen_low_q <= seen_low_d;
        end
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_spi_tx_en   = tx_en_q;
    assign o_spi_tx_data = tx_data_q;
    assign o_rx_drop     = drop_q;

endmodule

// File: doc/spi_burst_sequencer.md
Name: spi_burst_sequencer

Overview:
Upstream stage that feeds spi_controller. It buffers host write bytes in a TX FIFO and runs an N-byte burst as back-to-back single-byte controller transactions, driving i_tx_en/i_tx_data. Each received byte (o_rx_ack/o_rx_data) is captured into an RX FIFO that the host drains with valid/ready. The block sits between the register/host interface and spi_controller, in the same clock domain.

Parameters:
DATA_BW, 8, byte width; must match the controller's DATA_BW
LEN_BW, 8, width of the burst length input; max burst = 2^LEN_BW-1 bytes
FIFO_DEPTH, 16, entries per FIFO; power of 2, >= 2
FILL_BYTE, 8'hFF, byte sent on TX underflow (only with SPI_SEQ_FILL_EN)

Ports:
i_clk  in  1  system clock
i_rstn  in  1  reset; synchronous, active-low
i_wr_en  in  1  TX FIFO write strobe; ignored when o_tx_full
i_wr_data  in  DATA_BW  TX FIFO write data
o_tx_full  out  1  TX FIFO full
i_start  in  1  burst start pulse; ignored while o_busy
i_len  in  LEN_BW  burst byte count; sampled on accepted i_start
o_busy  out  1  burst in progress
o_done  out  1  one-cycle pulse at burst completion
o_rx_valid  out  1  RX FIFO not empty
o_rx_data  out  DATA_BW  RX FIFO head; valid only when o_rx_valid
i_rx_ready  in  1  pop RX head when o_rx_valid
o_rx_drop  out  1  one-cycle pulse: received byte discarded because RX FIFO full
o_spi_tx_en  out  1  to controller i_tx_en; registered single-cycle pulse
o_spi_tx_data  out  DATA_BW  to controller i_tx_data; held stable from pulse until next pulse
i_spi_tx_ready  in  1  from controller o_tx_ready
i_spi_rx_ack  in  1  from controller o_rx_ack
i_spi_rx_data  in  DATA_BW  from controller o_rx_data

Behaviour:
- Reset (i_rstn=0 at posedge): state IDLE; both FIFOs empty (pointers/counts 0). Output reset values: o_busy=0, o_done=0, o_spi_tx_en=0, o_spi_tx_data=0, o_rx_drop=0, o_tx_full=0, o_rx_valid=0. o_rx_data is don't-care.
- Reset mid-burst: the burst is abandoned and no o_done is issued. The controller shares i_rstn, so it also returns to idle.
- All outputs are registered except o_tx_full, o_rx_valid and o_rx_data, which decode directly from FIFO state.
- FIFOs: write is accepted iff not full; read is accepted iff not empty. Simultaneous write and read on a non-full/non-empty FIFO keeps the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Remaining-byte counter: LEN_BW bits, loaded from i_len on an accepted start, decremented on each captured ack.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_RDY.
  - IDLE: on i_start with i_len!=0 -> ISSUE; o_busy=1 from the next cycle. On i_start with i_len==0 -> stay IDLE; o_done pulses next cycle and o_busy stays 0.
  - ISSUE: when i_spi_tx_ready=1 and the TX FIFO is non-empty -> pop the FIFO, load o_spi_tx_data, pulse o_spi_tx_en for exactly one cycle, go to WAIT_ACK. When the TX FIFO is empty -> stall in ISSUE (default build).
  - WAIT_ACK: i_spi_tx_ready is ignored. On i_spi_rx_ack: push i_spi_rx_data into the RX FIFO, or pulse o_rx_drop if the FIFO is full. The drop still counts as a completed byte. Then decrement the count: if it reaches 0 -> IDLE with o_done=1 and o_busy=0 next cycle; otherwise -> WAIT_RDY.
  - WAIT_RDY: wait for i_spi_tx_ready=0->1 (controller back in IDLE) -> ISSUE.
- Latency: with data queued and the controller ready, i_start at cycle t gives o_spi_tx_en at t+2 (IDLE->ISSUE, then the registered pulse).
- Host pop and RX push in the same cycle are both honoured.
- TX writes are permitted during a burst, so the host can refill while bytes are being shifted out.

Optional Feature:
SPI_SEQ_FILL_EN
- Defined: in ISSUE with the TX FIFO empty and i_spi_tx_ready=1, send FILL_BYTE instead of stalling. No FIFO pop occurs. This supports read-only bursts.
- Undefined: ISSUE stalls until TX data arrives, and FILL_BYTE is unused.

Decomposition:
- Package spi_seq_pkg holds the FSM state encoding constants and the default FILL_BYTE.
- One sub-module, spi_seq_fifo (parameters DATA_BW, FIFO_DEPTH; synchronous reset; full/empty/count outputs), instantiated twice: once for TX, once for RX.

Test Plan:
- Directed loopback with the controller (mode 0, MISO tied to MOSI): write A5,3C,0F; start len=3 -> three tx_en pulses carrying A5,3C,0F; RX FIFO reads A5,3C,0F; one o_done; o_busy low afterwards.
- Start with len=0 -> o_done pulses one cycle later; no tx_en; o_busy never asserts.
- Start len=2 with only 1 byte queued (default build) -> second tx_en withheld; write 77 after 50 cycles -> 77 transmitted, then done.
- SPI_SEQ_FILL_EN build, empty TX FIFO, start len=4 -> four transactions with MOSI=FF; four RX bytes captured.
- FIFO_DEPTH=4, host holds i_rx_ready=0, burst len=6 -> bytes 5 and 6 each produce an o_rx_drop pulse; RX holds the first 4; o_done still pulses.
- Assert i_rstn=0 during WAIT_ACK of a len=3 burst -> next cycle: busy=0, FIFOs empty, no o_done; new start len=1 completes normally.
